// File: rtl/mdu32_iterative.sv
// rtl/mdu32_iterative.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
// 32 radix-2 steps in RUN, then a two-cycle FIX: sign/divide-by-zero correction, then HI/LO commit.
module mdu32_iterative #(
  parameter logic [31:0] DBZ_LO   = 32'hFFFF_FFFF,
  parameter bit          DBZ_HI_A = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] acc_hi, acc_lo, opnd, dividend;
  logic        is_div, neg_res, neg_rem, dbz;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ok;
  logic [31:0] div_diff;
  logic [63:0] prod_neg;

  assign busy = (state != IDLE);

  // op[0] set means unsigned, so magnitudes are taken only for MULT/DIV
  assign a_neg = ~op[0] & a[31];
  assign b_neg = ~op[0] & b[31];
  assign a_mag = a_neg ? (32'd0 - a) : a;
  assign b_mag = b_neg ? (32'd0 - b) : b;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
  assign div_sh   = {acc_hi, acc_lo[31]};
  assign div_ok   = (div_sh >= {1'b0, opnd});
  assign div_diff = div_sh[31:0] - opnd;
  assign prod_neg = 64'd0 - {acc_hi, acc_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == 5'd31) state_next = FIX;
      FIX:     if (count[0]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
      count    <= 5'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      opnd     <= 32'd0;
      dividend <= 32'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            count    <= 5'd0;
            is_div   <= op[1];
            dividend <= a;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            dbz      <= op[1] & (b == 32'd0);
            acc_hi   <= 32'd0;
            acc_lo   <= op[1] ? a_mag : b_mag;
            opnd     <= op[1] ? b_mag : a_mag;
          end
        end
        RUN: begin
          // count wraps 31 -> 0, which is the first FIX phase
          count <= count + 5'd1;
          if (is_div) begin
            acc_hi <= div_ok ? div_diff : div_sh[31:0];
            acc_lo <= {acc_lo[30:0], div_ok};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
          end
        end
        FIX: begin
          if (!count[0]) begin
            count <= 5'd1;
            if (!is_div) begin
              if (neg_res) {acc_hi, acc_lo} <= prod_neg;
            end else if (dbz) begin
              acc_lo <= DBZ_LO;
              acc_hi <= DBZ_HI_A ? dividend : 32'd0;
            end else begin
              if (neg_res) acc_lo <= 32'd0 - acc_lo;
              if (neg_rem) acc_hi <= 32'd0 - acc_hi;
            end
          end else begin
            count <= 5'd0;
            hi    <= acc_hi;
            lo    <= acc_lo;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu32_iterative.sv
// tb/tb_mdu32_iterative.sv - scoreboard bench for mdu32_iterative
// Stimulus pushes expected HI/LO; a negedge monitor pops on every done pulse.
module tb_mdu32_iterative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  mdu32_iterative dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
        chk({e.nm, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input string nm,
                        input bit push);
    int w;
    w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (busy) chk({nm, "_idle_timeout"}, 64'd1, 64'd0);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) sb.push_back('{eh, el, nm});
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  // elapsed: negedges already spent since the accept edge's following negedge
  task automatic finish_op(input string nm, input int elapsed);
    int  bcnt;
    int  lat;
    bit  seen;
    bcnt = 0;
    lat  = elapsed;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (busy) bcnt++;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({nm, "_done_seen"}, {63'd0, seen}, 64'd1);
    chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(34 - elapsed));
    chk({nm, "_latency"}, 64'(lat), 64'd34);
    @(negedge clk);
    chk({nm, "_done_single"}, {63'd0, done}, 64'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    launch(o, x, y, eh, el, nm, 1'b1);
    finish_op(nm, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    a = 32'd0;
    b = 32'd0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
    run_op(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    run_op(DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7by2");
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow");
    run_op(DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by_zero");
    run_op(DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, "div_100_by_neg7");

    // start and MTHI during busy must both be ignored
    launch(DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, "divu_busy_ignore", 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op = MULTU;
    a = 32'd3;
    b = 32'd5;
    hi_we = 1'b1;
    wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    chk("busy_hi_stable", {32'd0, hi}, {32'd0, 32'hFFFF_FFF2 ^ 32'hFFFF_FFF0});
    finish_op("divu_busy_ignore", 6);
    repeat (40) @(negedge clk);
    chk("busy_start_dropped", {63'd0, busy}, 64'd0);

    // MTLO in idle, then MTHI+MTLO together
    lo_we = 1'b1;
    wdata = 32'd5;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", {32'd0, lo}, 64'd5);
    chk("mtlo_hi_kept", {32'd0, hi}, 64'd2);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h1357_9BDF;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mthi_mtlo_hi", {32'd0, hi}, {32'd0, 32'h1357_9BDF});
    chk("mthi_mtlo_lo", {32'd0, lo}, {32'd0, 32'h1357_9BDF});

    // write and start in the same idle cycle: write lands, FIX later overwrites
    start = 1'b1;
    op = MULTU;
    a = 32'd2;
    b = 32'd3;
    hi_we = 1'b1;
    wdata = 32'h0000_0077;
    sb.push_back('{32'd0, 32'd6, "start_with_mthi"});
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    chk("start_with_mthi_written", {32'd0, hi}, 64'h77);
    chk("start_with_mthi_busy", {63'd0, busy}, 64'd1);
    finish_op("start_with_mthi", 0);

    // reset at cycle 10 of a MULT aborts with no result
    launch(MULT, 32'h0000_0005, 32'hFFFF_FFFF, 32'd0, 32'd0, "mult_reset", 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_hi", {32'd0, hi}, 64'd0);
    chk("midreset_lo", {32'd0, lo}, 64'd0);
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset_no_result_lo", {32'd0, lo}, 64'd0);

    run_op(MULT, 32'h0000_0010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFE0, "mult_after_reset");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
